seq_detect_param: RTL and testbench
===================================

// Module: seq_detect_param
// PURPOSE
//  Parametrised serial bit-pattern detector, successor to the fixed 5-bit "10101" detector.
//  - Shifts one serial bit per enabled clock and compares the history against a PAT_W-bit
//    compile-time pattern.
//  - Selectable overlapping / non-overlapping detection.
//  - Suppresses false matches until PAT_W bits have been accepted.
//  - Keeps a saturating match counter.
//  - Sits between a serial input source and downstream event/LED logic.
// PARAMETERS
//  PAT_W    5         pattern length in bits (legal 2..16)
//  PATTERN  5'b10101  pattern to detect; MSB = oldest bit, LSB = newest bit
//  CNT_W    8         width of match counter (legal 1..16)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous reset, active-low
//  en         in   1      data qualifier; data is accepted only when en=1
//  data       in   1      serial input bit
//  overlap    in   1      1 = overlapping detection, 0 = non-overlapping
//  clear      in   1      synchronous clear of history, fill, match and counter
//  match      out  1      registered one-cycle match pulse
//  match_cnt  out  CNT_W  number of matches since reset/clear, saturating
//  cnt_sat    out  1      high while match_cnt == all ones
//  hist       out  PAT_W  current shift history, LSB = newest bit
// BEHAVIOUR
//  Reset (rst=0, asynchronous):
//  - hist=0, fill=0, match=0, match_cnt=0, cnt_sat=0.
//  - All outputs are registered; no combinational path from inputs to outputs.
//  Internal fill counter:
//  - Counts accepted bits, saturating at PAT_W.
//  Accept edge (en=1, clear=0):
//  - nxt = {hist[PAT_W-2:0], data}.
//  - hit = (nxt == PATTERN) && (fill >= PAT_W-1).
//  - match <= hit.
//  - On hit, match_cnt increments unless saturated.
//  Latency:
//  - match is high for exactly the one cycle following the edge that sampled the final pattern bit.
//  After a hit:
//  - overlap=1: hist <= nxt; fill stays at PAT_W.
//  - overlap=0: hist <= 0 and fill <= 0, so the next match needs PAT_W fresh bits.
//  - overlap is sampled on every accept edge; changing it mid-stream takes effect from that edge.
//  - No hit: hist <= nxt; fill <= min(fill+1, PAT_W).
//  en=0 (clear=0):
//  - hist, fill and match_cnt hold.
//  - match <= 0; data is ignored.
//  clear=1:
//  - Takes priority over en.
//  - Next edge sets hist=0, fill=0, match=0, match_cnt=0.
//  Counter saturation:
//  - match_cnt holds at 2^CNT_W-1; further hits still pulse match.
//  - cnt_sat = (match_cnt == all ones), registered alongside match_cnt.
//  Reset mid-stream:
//  - Partial history is discarded immediately.
//  - A pattern straddling the reset never matches.
//  Pattern of all zeros:
//  - Reset-zero history never satisfies hit, because fill gates it.
// TESTING
//  1. Defaults, overlap=1, en=1, bits 1,0,1,0,1,0,1 -> match pulses after bit 5 and after bit 7;
//     match_cnt=2.
//  2. Defaults, overlap=0, same 7 bits -> single pulse after bit 5; match_cnt=1; hist=5'b00001
//     after bit 7 (only bits 6-7 "01" retained after the post-match clear).
//  3. PATTERN=5'b00000: 4 zeros after reset -> no match; 5th zero -> match=1 (fill gating).
//  4. Bits 1,0,1 with en=1, two cycles en=0 (data toggling), then 0,1 with en=1 -> one match;
//     en=0 cycles leave hist unchanged.
//  5. CNT_W=2, overlap=1, stream 101010101010 -> 4 matches; match_cnt stops at 3; cnt_sat=1;
//     match still pulses on the 4th hit.
//  6. Feed 1,0,1,0; assert rst low mid-cycle -> outputs clear immediately; then 1 -> no match;
//     clear=1 with en=1 -> clear wins and match_cnt=0.

Source files
------------

// File: rtl/seq_detect_param_if.sv
// rtl/seq_detect_param_if.sv - serial input/detect output bundle for seq_detect_param
interface seq_detect_param_if #(
  parameter int PAT_W = 5,
  parameter int CNT_W = 8
);
  logic             en;
  logic             data;
  logic             overlap;
  logic             clear;
  logic             match;
  logic [CNT_W-1:0] match_cnt;
  logic             cnt_sat;
  logic [PAT_W-1:0] hist;

  modport master (
    output en, data, overlap, clear,
    input  match, match_cnt, cnt_sat, hist
  );

  modport slave (
    input  en, data, overlap, clear,
    output match, match_cnt, cnt_sat, hist
  );
endinterface

// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - parametrised serial pattern detector with saturating match counter
module seq_detect_param #(
  parameter int               PAT_W   = 5,
  parameter logic [PAT_W-1:0] PATTERN = 5'b10101,
  parameter int               CNT_W   = 8
) (
  input logic               clk,
  input logic               rst,
  seq_detect_param_if.slave bus
);
  localparam int               FILL_W   = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MIN = FILL_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  logic [PAT_W-1:0]  hist_q;
  logic [FILL_W-1:0] fill_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              match_q;
  logic              sat_q;

  logic [PAT_W-1:0]  nxt;
  logic              hit;
  logic [CNT_W-1:0]  cnt_nxt;

  // fill gating keeps reset-zero history from matching an all-zero pattern
  always_comb begin
    nxt     = {hist_q[PAT_W-2:0], bus.data};
    hit     = (nxt == PATTERN) && (fill_q >= FILL_MIN);
    cnt_nxt = cnt_q;
    if (hit && (cnt_q != CNT_MAX)) cnt_nxt = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      match_q <= 1'b0;
      sat_q   <= 1'b0;
    end else if (bus.clear) begin
      hist_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      match_q <= 1'b0;
      sat_q   <= 1'b0;
    end else if (bus.en) begin
      match_q <= hit;
      cnt_q   <= cnt_nxt;
      sat_q   <= (cnt_nxt == CNT_MAX);
      // non-overlapping mode restarts from an empty history after each hit
      if (hit && !bus.overlap) begin
        hist_q <= '0;
        fill_q <= '0;
      end else begin
        hist_q <= nxt;
        fill_q <= (fill_q == FILL_MAX) ? fill_q : fill_q + FILL_W'(1);
      end
    end else begin
      match_q <= 1'b0;
    end
  end

  assign bus.match     = match_q;
  assign bus.match_cnt = cnt_q;
  assign bus.cnt_sat   = sat_q;
  assign bus.hist      = hist_q;
endmodule

// File: tb/tb_seq_detect_param.sv
// tb/tb_seq_detect_param.sv - scoreboard bench for three seq_detect_param variants
module tb_seq_detect_param;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0, data = 1'b0, overlap = 1'b1, clear = 1'b0;

  always #5 clk = ~clk;

  seq_detect_param_if #(.PAT_W(5), .CNT_W(8)) a_if ();
  seq_detect_param_if #(.PAT_W(5), .CNT_W(8)) z_if ();
  seq_detect_param_if #(.PAT_W(5), .CNT_W(2)) s_if ();

  assign a_if.en = en; assign a_if.data = data; assign a_if.overlap = overlap; assign a_if.clear = clear;
  assign z_if.en = en; assign z_if.data = data; assign z_if.overlap = overlap; assign z_if.clear = clear;
  assign s_if.en = en; assign s_if.data = data; assign s_if.overlap = overlap; assign s_if.clear = clear;

  seq_detect_param #(.PAT_W(5), .PATTERN(5'b10101), .CNT_W(8)) u_a (.clk(clk), .rst(rst), .bus(a_if.slave));
  seq_detect_param #(.PAT_W(5), .PATTERN(5'b00000), .CNT_W(8)) u_z (.clk(clk), .rst(rst), .bus(z_if.slave));
  seq_detect_param #(.PAT_W(5), .PATTERN(5'b10101), .CNT_W(2)) u_s (.clk(clk), .rst(rst), .bus(s_if.slave));

  typedef struct {
    int k;
    bit match;
    int cnt;
    bit sat;
    int hist;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  int m_hist[3];
  int m_fill[3];
  int m_cnt[3];
  bit m_match[3];
  bit m_sat[3];
  int m_pat[3]  = '{5'b10101, 5'b00000, 5'b10101};
  int m_cmax[3] = '{255, 255, 3};

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic obs(input int k, output exp_t o);
    o.k = k;
    case (k)
      0: begin o.match = a_if.match; o.cnt = int'(a_if.match_cnt); o.sat = a_if.cnt_sat; o.hist = int'(a_if.hist); end
      1: begin o.match = z_if.match; o.cnt = int'(z_if.match_cnt); o.sat = z_if.cnt_sat; o.hist = int'(z_if.hist); end
      default: begin o.match = s_if.match; o.cnt = int'(s_if.match_cnt); o.sat = s_if.cnt_sat; o.hist = int'(s_if.hist); end
    endcase
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_hist[k] = 0; m_fill[k] = 0; m_cnt[k] = 0; m_match[k] = 0; m_sat[k] = 0;
    end
  endtask

  // Reference behaviour of one accepted/held/cleared cycle, written from the bit-level description
  task automatic model_step(input bit e, input bit d, input bit ov, input bit c);
    for (int k = 0; k < 3; k++) begin
      if (c) begin
        m_hist[k] = 0; m_fill[k] = 0; m_cnt[k] = 0; m_match[k] = 0; m_sat[k] = 0;
      end else if (e) begin
        int nxt;
        bit hit;
        nxt = ((m_hist[k] * 2) + int'(d)) % 32;
        hit = (nxt == m_pat[k]) && (m_fill[k] >= 4);
        m_match[k] = hit;
        if (hit && m_cnt[k] < m_cmax[k]) m_cnt[k]++;
        m_sat[k] = (m_cnt[k] == m_cmax[k]);
        if (hit && !ov) begin
          m_hist[k] = 0; m_fill[k] = 0;
        end else begin
          m_hist[k] = nxt;
          if (m_fill[k] < 5) m_fill[k]++;
        end
      end else begin
        m_match[k] = 0;
      end
      sb_q.push_back('{k, m_match[k], m_cnt[k], m_sat[k], m_hist[k]});
    end
  endtask

  task automatic check_outputs(input string tag);
    exp_t e, o;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      obs(e.k, o);
      chk($sformatf("%s_d%0d_match", tag, e.k), int'(o.match), int'(e.match));
      chk($sformatf("%s_d%0d_cnt", tag, e.k), o.cnt, e.cnt);
      chk($sformatf("%s_d%0d_sat", tag, e.k), int'(o.sat), int'(e.sat));
      chk($sformatf("%s_d%0d_hist", tag, e.k), o.hist, e.hist);
    end
  endtask

  task automatic apply(input string tag, input bit e, input bit d, input bit ov, input bit c);
    @(negedge clk);
    en = e; data = d; overlap = ov; clear = c;
    model_step(e, d, ov, c);
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic feed(input string tag, input int bits, input int n, input bit ov);
    for (int i = n - 1; i >= 0; i--) apply(tag, 1'b1, bits[i], ov, 1'b0);
  endtask

  initial begin
    model_reset();
    #12;
    chk("rst_match", int'(a_if.match), 0);
    chk("rst_cnt", int'(a_if.match_cnt), 0);
    chk("rst_sat", int'(s_if.cnt_sat), 0);
    chk("rst_hist", int'(a_if.hist), 0);
    @(negedge clk);
    rst = 1'b1;

    feed("t1", 7'b1010101, 7, 1'b1);
    chk("t1_cnt2", int'(a_if.match_cnt), 2);
    apply("clr", 1'b0, 1'b0, 1'b1, 1'b1);

    feed("t2", 7'b1010101, 7, 1'b0);
    chk("t2_cnt1", int'(a_if.match_cnt), 1);
    chk("t2_hist", int'(a_if.hist), 5'b00001);
    apply("clr", 1'b0, 1'b0, 1'b1, 1'b1);

    feed("t3a", 0, 4, 1'b1);
    chk("t3_nomatch4", int'(z_if.match), 0);
    feed("t3b", 0, 1, 1'b1);
    chk("t3_match5", int'(z_if.match), 1);
    apply("clr", 1'b0, 1'b0, 1'b1, 1'b1);

    feed("t4a", 3'b101, 3, 1'b1);
    apply("t4_hold", 1'b0, 1'b0, 1'b1, 1'b0);
    apply("t4_hold", 1'b0, 1'b1, 1'b1, 1'b0);
    chk("t4_hist_held", int'(a_if.hist), 5'b00101);
    feed("t4b", 2'b01, 2, 1'b1);
    chk("t4_match", int'(a_if.match), 1);
    apply("clr", 1'b0, 1'b0, 1'b1, 1'b1);

    feed("t5a", 12'b1010_1010_1, 9, 1'b1);
    feed("t5b", 3'b010, 3, 1'b1);
    chk("t5_cnt_sat3", int'(s_if.match_cnt), 3);
    chk("t5_sat", int'(s_if.cnt_sat), 1);
    apply("t5_last", 1'b1, 1'b1, 1'b1, 1'b0);
    chk("t5_pulse_sat", int'(s_if.match), 1);
    apply("clr", 1'b0, 1'b0, 1'b1, 1'b1);

    feed("t6a", 4'b1010, 4, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    chk("t6_rst_hist", int'(a_if.hist), 0);
    chk("t6_rst_cnt", int'(s_if.match_cnt), 0);
    @(negedge clk);
    rst = 1'b1;
    feed("t6b", 1, 1, 1'b1);
    chk("t6_nomatch", int'(a_if.match), 0);
    apply("t6_clr", 1'b1, 1'b1, 1'b1, 1'b1);
    chk("t6_clr_cnt", int'(a_if.match_cnt), 0);

    for (int i = 0; i < 300; i++) begin
      bit e, d, ov, c;
      e  = ($urandom_range(0, 4) != 0);
      d  = $urandom_range(0, 1);
      ov = ($urandom_range(0, 7) != 0);
      c  = ($urandom_range(0, 60) == 0);
      apply("rnd", e, d, ov, c);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
